ps2_scan_decoder: RTL and testbench

- Decodes the PS/2 set-2 scan-code byte stream popped from the keyboard receiver FIFO into key events.
- Sits directly downstream of ps2_keyboard and upstream of the seven-segment display logic.
- Tracks make, break, E0-extended and typematic repeat.
- Outputs the currently held key (raw code and ASCII) plus a press counter.

---
 rtl/ps2_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code stream decoder: make/break/E0/typematic tracking of a single held key.
// Optional PS2_SHIFT_EN macro adds left/right shift tracking for upper-case letter ASCII.
module ps2_scan_decoder #(
    parameter int unsigned CNT_W         = 8,
    parameter bit          IGNORE_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             code_valid,
    input  logic [7:0]       code,
    output logic             code_pop_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_count,
    output logic             press_pulse,
    output logic             release_pulse
);

    typedef enum logic [1:0] {IDLE, DECODE, GAP} state_e;

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             pop_n_q, pop_n_d;
    logic             valid_q, valid_d;
    logic [7:0]       kcode_q, kcode_d;
    logic             kext_q, kext_d;
    logic [7:0]       ascii_q, ascii_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic             shift_held_c;
    logic             shift_key_c;
    logic             same_key_c;

`ifdef PS2_SHIFT_EN
    logic shift_q, shift_d;
    assign shift_held_c = shift_q;
    assign shift_key_c  = ((byte_q == 8'h12) || (byte_q == 8'h59)) && !ext_pend_q;
`else
    assign shift_held_c = 1'b0;
    assign shift_key_c  = 1'b0;
`endif

    assign same_key_c = valid_q && (byte_q == kcode_q) && (ext_pend_q == kext_q);

    // Set-2 code to ASCII; extended codes are never mapped.
    function automatic logic [7:0] ascii_lookup(input logic [7:0] b, input logic e, input logic sh);
        logic [7:0] a;
        a = 8'h00;
        case (b)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        if (e) a = 8'h00;
        if (sh && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
        return a;
    endfunction

    // Next-state and result logic; results only change in DECODE.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        pop_n_d    = 1'b1;
        valid_d    = valid_q;
        kcode_d    = kcode_q;
        kext_d     = kext_q;
        ascii_d    = ascii_q;
        cnt_d      = cnt_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
`ifdef PS2_SHIFT_EN
        shift_d    = shift_q;
`endif
        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    byte_d  = code;
                    pop_n_d = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = GAP;
                case (byte_q)
                    8'hE0: ext_pend_d = 1'b1;
                    8'hF0: brk_pend_d = 1'b1;
                    8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                    default: begin
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        if (shift_key_c) begin
`ifdef PS2_SHIFT_EN
                            shift_d = !brk_pend_q;
`endif
                        end else if (brk_pend_q) begin
                            if (same_key_c) begin
                                valid_d = 1'b0;
                                rel_d   = 1'b1;
                            end
                        end else if (same_key_c) begin
                            if (!IGNORE_REPEAT) begin
                                press_d = 1'b1;
                                cnt_d   = cnt_q + CNT_W'(1);
                            end
                        end else begin
                            kcode_d = byte_q;
                            kext_d  = ext_pend_q;
                            ascii_d = ascii_lookup(byte_q, ext_pend_q, shift_held_c);
                            valid_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            byte_q     <= 8'h00;
            pop_n_q    <= 1'b1;
            valid_q    <= 1'b0;
            kcode_q    <= 8'h00;
            kext_q     <= 1'b0;
            ascii_q    <= 8'h00;
            cnt_q      <= '0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
`ifdef PS2_SHIFT_EN
            shift_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            pop_n_q    <= pop_n_d;
            valid_q    <= valid_d;
            kcode_q    <= kcode_d;
            kext_q     <= kext_d;
            ascii_q    <= ascii_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
`ifdef PS2_SHIFT_EN
            shift_q    <= shift_d;
`endif
        end
    end

    assign code_pop_n    = pop_n_q;
    assign key_valid     = valid_q;
    assign key_code      = kcode_q;
    assign key_ext       = kext_q;
    assign key_ascii     = ascii_q;
    assign press_count   = cnt_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: FIFO stand-in, byte-stream reference model, scenario tasks.
module tb_ps2_scan_decoder;

    localparam int unsigned CNT_W  = 8;
    localparam bit          IGN_RP = 1'b1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             code_valid = 1'b0;
    logic [7:0]       code = 8'h00;
    logic             code_pop_n;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic [7:0]       key_ascii;
    logic [CNT_W-1:0] press_count;
    logic             press_pulse;
    logic             release_pulse;

    ps2_scan_decoder #(.CNT_W(CNT_W), .IGNORE_REPEAT(IGN_RP)) dut (
        .clk(clk), .rstn(rstn), .code_valid(code_valid), .code(code),
        .code_pop_n(code_pop_n), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_ascii(key_ascii), .press_count(press_count),
        .press_pulse(press_pulse), .release_pulse(release_pulse)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo[$];
    int cyc = 0, pop_cnt = 0, press_hi = 0, rel_hi = 0, both_hi = 0;
    int last_pop_cyc = 0, last_press_cyc = 0;
    int pop_cycles[$];

    // Receiver FIFO stand-in and output monitor, all at the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!code_pop_n) begin
            pop_cnt++;
            last_pop_cyc = cyc;
            pop_cycles.push_back(cyc);
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        if (press_pulse) begin press_hi++; last_press_cyc = cyc; end
        if (release_pulse) rel_hi++;
        if (press_pulse && release_pulse) both_hi++;
        code_valid = (fifo.size() != 0);
        code = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    // Reference model: key state derived from the byte stream.
    logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    bit m_valid, m_ext, m_ext_pend, m_brk_pend, m_shift;
    logic [7:0] m_code, m_ascii;
    int m_count, m_press, m_rel;

    function automatic logic [7:0] m_lookup(logic [7:0] b, bit e, bit sh);
        if (e) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (letters[i] == b) return 8'((sh ? 8'h41 : 8'h61) + i);
        for (int i = 0; i < 10; i++)
            if (digits[i] == b) return 8'(8'h30 + i);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    function automatic void m_apply(logic [7:0] b);
        bit same;
        bit is_shift;
        if (b == 8'hE0) begin m_ext_pend = 1; return; end
        if (b == 8'hF0) begin m_brk_pend = 1; return; end
        if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF}) begin
            m_ext_pend = 0; m_brk_pend = 0; return;
        end
        same = m_valid && (b == m_code) && (m_ext_pend == m_ext);
`ifdef PS2_SHIFT_EN
        is_shift = (b == 8'h12 || b == 8'h59) && !m_ext_pend;
`else
        is_shift = 0;
`endif
        if (is_shift) m_shift = !m_brk_pend;
        else if (m_brk_pend) begin
            if (same) begin m_valid = 0; m_rel++; end
        end else if (same) begin
            if (!IGN_RP) begin m_press++; m_count = (m_count + 1) % 256; end
        end else begin
            m_code = b; m_ext = m_ext_pend; m_ascii = m_lookup(b, m_ext_pend, m_shift);
            m_valid = 1; m_press++; m_count = (m_count + 1) % 256;
        end
        m_ext_pend = 0; m_brk_pend = 0;
    endfunction

    function automatic logic [25:0] exp_vec();
        return {m_valid, m_ext, m_code, m_ascii, 8'(m_count)};
    endfunction

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        m_apply(b);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (fifo.size() != 0 && n < budget) begin @(posedge clk); n++; end
        checks++;
        if (fifo.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout fifo_left %0d exp 0", fifo.size());
            fifo.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 0;
        fifo.delete();
        @(posedge clk); #1;
        rstn = 1;
        m_valid = 0; m_ext = 0; m_code = 0; m_ascii = 0; m_count = 0;
        m_ext_pend = 0; m_brk_pend = 0; m_shift = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        checks++;
        if (code_pop_n !== 1'b1) begin errors++; $display("FAIL reset_pop_n got %0b exp 1", code_pop_n); end
        checks++;
        if ({key_valid, key_ext, key_code, key_ascii, press_count} !== 26'h0) begin
            errors++; $display("FAIL reset_state got %h exp 0", {key_valid, key_ext, key_code, key_ascii, press_count});
        end
        checks++;
        if ({press_pulse, release_pulse} !== 2'b00) begin
            errors++; $display("FAIL reset_pulses got %b exp 00", {press_pulse, release_pulse});
        end
        rstn = 1;
        m_press = 0; m_rel = 0;
        do_reset();
    endtask

    task automatic test_single_make();
        int p0 = pop_cnt;
        push(8'h1C);
        drain(50);
        checks++;
        if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL single_pops got %0d exp 1", pop_cnt - p0); end
        checks++;
        if (last_press_cyc - last_pop_cyc !== 1) begin
            errors++; $display("FAIL single_latency got %0d exp 1", last_press_cyc - last_pop_cyc);
        end
        checks++;
        if ({key_valid, key_code, key_ascii, press_count} !== {1'b1, 8'h1C, 8'h61, 8'd1}) begin
            errors++; $display("FAIL single_key got %h exp %h", {key_valid, key_code, key_ascii, press_count}, {1'b1, 8'h1C, 8'h61, 8'd1});
        end
        checks++;
        if (press_hi !== m_press) begin errors++; $display("FAIL single_press_cycles got %0d exp %0d", press_hi, m_press); end
    endtask

    task automatic test_repeat_release();
        int r0 = rel_hi;
        do_reset();
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain(100);
        checks++;
        if (press_count !== 8'd1) begin errors++; $display("FAIL repeat_count got %0d exp 1", press_count); end
        push(8'hF0); push(8'h1C);
        drain(100);
        checks++;
        if ({key_valid, key_code} !== {1'b0, 8'h1C}) begin
            errors++; $display("FAIL release_key got %h exp 01c", {key_valid, key_code});
        end
        checks++;
        if (rel_hi - r0 !== 1) begin errors++; $display("FAIL release_pulses got %0d exp 1", rel_hi - r0); end
    endtask

    task automatic test_extended();
        push(8'hE0); push(8'h75);
        drain(100);
        checks++;
        if ({key_valid, key_ext, key_code, key_ascii} !== {1'b1, 1'b1, 8'h75, 8'h00}) begin
            errors++; $display("FAIL ext_make got %h exp %h", {key_valid, key_ext, key_code, key_ascii}, {1'b1, 1'b1, 8'h75, 8'h00});
        end
        push(8'hE0); push(8'hF0); push(8'h75);
        drain(100);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL ext_break got %0b exp 0", key_valid); end
        checks++;
        if ({key_valid, key_ext, key_code, key_ascii, press_count} !== exp_vec()) begin
            errors++; $display("FAIL ext_model got %h exp %h", {key_valid, key_ext, key_code, key_ascii, press_count}, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pop_cycles.delete();
        push(8'h16); push(8'hF0); push(8'h16);
        drain(100);
        checks++;
        if (pop_cycles.size() !== 3) begin errors++; $display("FAIL b2b_pops got %0d exp 3", pop_cycles.size()); end
        else begin
            checks++;
            if (pop_cycles[1] - pop_cycles[0] !== 3 || pop_cycles[2] - pop_cycles[1] !== 3) begin
                errors++; $display("FAIL b2b_spacing got %0d,%0d exp 3,3", pop_cycles[1] - pop_cycles[0], pop_cycles[2] - pop_cycles[1]);
            end
        end
        checks++;
        if ({press_count, key_ascii} !== {8'd1, 8'h31}) begin
            errors++; $display("FAIL b2b_result got %h exp 0131", {press_count, key_ascii});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin push(8'h29); push(8'hF0); push(8'h29); end
        drain(5000);
        checks++;
        if ({key_valid, key_ascii, press_count} !== {1'b0, 8'h20, 8'h00}) begin
            errors++; $display("FAIL wrap got %h exp 02000", {key_valid, key_ascii, press_count});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(8'hF0);
        drain(50);
        do_reset();
        push(8'h1C);
        drain(50);
        checks++;
        if ({key_valid, press_count} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL reset_mid got %h exp 101", {key_valid, press_count});
        end
    endtask

    task automatic test_shift();
        logic [7:0] exp_cnt, exp_asc;
`ifdef PS2_SHIFT_EN
        exp_cnt = 8'd1; exp_asc = 8'h41;
`else
        exp_cnt = 8'd2; exp_asc = 8'h61;
`endif
        do_reset();
        push(8'h12); push(8'h1C);
        drain(50);
        checks++;
        if ({press_count, key_ascii} !== {exp_cnt, exp_asc}) begin
            errors++; $display("FAIL shift got %h exp %h", {press_count, key_ascii}, {exp_cnt, exp_asc});
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[16] = '{8'hE0, 8'hF0, 8'hF0, 8'h00, 8'hAA, 8'hFA, 8'h1C, 8'h1C,
                                  8'h32, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h75, 8'h12, 8'h59};
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 20; k++) begin
                push(pool[$urandom_range(0, 15)]);
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
            drain(400);
            checks++;
            if ({key_valid, key_ext, key_code, key_ascii, press_count} !== exp_vec()) begin
                errors++; $display("FAIL random_state round %0d got %h exp %h", r, {key_valid, key_ext, key_code, key_ascii, press_count}, exp_vec());
            end
            checks++;
            if (press_hi !== m_press || rel_hi !== m_rel) begin
                errors++; $display("FAIL random_pulses round %0d got %0d/%0d exp %0d/%0d", r, press_hi, rel_hi, m_press, m_rel);
            end
        end
        checks++;
        if (both_hi !== 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_repeat_release();
        test_extended();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
